// File: rtl/display_arbiter_if.sv
// Source-side bundle of the display arbiter: requests and values in, grant and display value out.
interface display_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][15:0] req_value;
  logic [NREQ-1:0]       grant;
  logic [15:0]           value;
  logic [2:0]            owner;
  logic                  busy;

  modport master (output req, req_value, input grant, value, owner, busy);
  modport slave  (input req, req_value, output grant, value, owner, busy);
endinterface

// File: rtl/display_arbiter.sv
// Round-robin time-share of the 7-segment display value with a minimum dwell per owner.
// Optional source-0 preemption is built when DISPLAY_ARB_PRIORITY_EN is defined.
module display_arbiter_lane (
  input  logic        sel,
  input  logic [15:0] src,
  output logic [15:0] masked
);
  assign masked = sel ? src : 16'h0000;
endmodule

module display_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          DWELL      = 50000000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input logic              clk,
  input logic              reset,
  display_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_ARB = 2'd2} state_e;

  localparam logic [27:0] CNT_LAST = 28'(DWELL - 1);
  localparam logic [2:0]  LAST_RST = 3'(NREQ - 1);

  state_e                state, state_nx;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [15:0]           value_q, value_d;
  logic [2:0]            owner_q, owner_d, last_q, last_d;
  logic                  busy_q, busy_d;
  logic [27:0]           cnt_q, cnt_d;
  logic                  any_req, own_req, other_req, dwell_end, preempt;
  logic [2:0]            pick;
  logic [NREQ-1:0]       pick_oh, src_oh;
  logic [NREQ-1:0][15:0] lane_val;
  logic [15:0]           src_val;
`ifdef DISPLAY_ARB_PRIORITY_EN
  logic                  prio_q, prio_d;
`endif

  // First requester after 'base', wrapping, ending at 'base' itself.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] base);
    logic [2:0] p;
    int         idx;
    p = base;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NREQ;
      if (r[idx]) p = 3'(idx);
    end
    return p;
  endfunction

  function automatic logic [NREQ-1:0] to_oh(input logic [2:0] i);
    logic [NREQ-1:0] oh;
    for (int k = 0; k < NREQ; k++) oh[k] = (int'(i) == k);
    return oh;
  endfunction

  assign any_req   = |bus.req;
  assign own_req   = |(bus.req & grant_q);
  assign other_req = |(bus.req & ~grant_q);
  assign dwell_end = (cnt_q == CNT_LAST);

`ifdef DISPLAY_ARB_PRIORITY_EN
  assign preempt = (state == S_HOLD) && !grant_q[0] && bus.req[0];
  assign pick    = (prio_q && bus.req[0]) ? 3'd0 : rr_pick(bus.req, last_q);
`else
  assign preempt = 1'b0;
  assign pick    = rr_pick(bus.req, last_q);
`endif

  assign pick_oh = to_oh(pick);
  // In HOLD the live owner is sampled; otherwise the source about to be granted.
  assign src_oh  = (state == S_HOLD) ? grant_q : pick_oh;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    display_arbiter_lane u_lane (
      .sel    (src_oh[i]),
      .src    (bus.req_value[i]),
      .masked (lane_val[i])
    );
  end

  always_comb begin
    src_val = 16'h0000;
    for (int i = 0; i < NREQ; i++) src_val = src_val | lane_val[i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      grant_q <= '0;
      value_q <= IDLE_VALUE;
      owner_q <= 3'd0;
      busy_q  <= 1'b0;
      cnt_q   <= 28'd0;
      last_q  <= LAST_RST;
`ifdef DISPLAY_ARB_PRIORITY_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      grant_q <= grant_d;
      value_q <= value_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef DISPLAY_ARB_PRIORITY_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any_req) state_nx = S_HOLD;
      S_HOLD:  if (!own_req || preempt || (dwell_end && other_req)) state_nx = S_ARB;
      S_ARB:   state_nx = any_req ? S_HOLD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    value_d = value_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef DISPLAY_ARB_PRIORITY_EN
    prio_d  = 1'b0;
`endif
    case (state)
      S_HOLD: begin
        // Value freezes on the edge the owner withdraws, otherwise tracks live.
        if (own_req) value_d = src_val;
        cnt_d = dwell_end ? 28'd0 : cnt_q + 28'd1;
        if (state_nx == S_ARB) begin
          grant_d = '0;
          owner_d = 3'd0;
          busy_d  = 1'b0;
          last_d  = owner_q;
`ifdef DISPLAY_ARB_PRIORITY_EN
          prio_d  = preempt;
`endif
        end
      end
      default: begin
        if (any_req) begin
          grant_d = pick_oh;
          owner_d = pick;
          busy_d  = 1'b1;
          cnt_d   = 28'd0;
          value_d = src_val;
        end else begin
          grant_d = '0;
          owner_d = 3'd0;
          busy_d  = 1'b0;
          value_d = IDLE_VALUE;
        end
      end
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.value = value_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Time-shares the 4-digit 7-segment display between up to NREQ independent value sources. It sits between the producers (counters, status registers, debug taps) and the segment driver, and feeds the driver's 16-bit `value` input. Arbitration is round-robin with a minimum dwell time per owner, so each source stays readable to a human before the next one takes over.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, legal 2..8.
- `DWELL`, 50000000: cycles per ownership slot, legal 2..2^28-1.
- `IDLE_VALUE`, 16'h0000: value driven when no source owns the display.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: synchronous, active-low reset.
- `req`  in  NREQ: request per source, level-sensitive; held high while the source wants the display.
- `req_value`  in  16*NREQ: source i value on bits [16*i+15:16*i].
- `grant`  out  NREQ: one-hot current owner; all zero when none.
- `value`  out  16: registered display value, connects to the segment driver.
- `owner`  out  3: index of current owner; 0 when `busy`=0.
- `busy`  out  1: high while any grant is asserted.

## Operation
- States: IDLE, HOLD, ARB. Internal regs: 28-bit dwell counter `cnt`, `last` (index of last owner).
- Reset values: state=IDLE, `grant`=0, `value`=IDLE_VALUE, `owner`=0, `busy`=0, `cnt`=0, `last`=NREQ-1. With `last`=NREQ-1, the first grant after reset goes to the lowest requesting index.
- Round-robin pick: first set bit of `req` scanning `last+1`, `last+2`, … modulo NREQ, ending at `last` itself.
- IDLE:
  - `req`==0: stay in IDLE.
  - Otherwise: go to HOLD, set `grant`/`owner` to the pick, load `value` from the picked source, and set `cnt`=0.
- HOLD:
  - Every cycle, `value` <= current owner's `req_value` (live tracking).
  - `cnt` increments each cycle.
  - Owner's `req` low: go to ARB. `grant` clears at the same edge and `value` holds.
  - Otherwise, when `cnt`==DWELL-1:
    - If another `req` bit is set: go to ARB.
    - If not: set `cnt`=0 and keep the owner.
- ARB (exactly one cycle):
  - `grant`=0, `busy`=0, `value` held.
  - `last` <= previous owner.
  - Next edge:
    - If `req`!=0: pick per round-robin and enter HOLD as from IDLE.
    - Else: go to IDLE and set `value` <= IDLE_VALUE.
- `req_value` of non-owners is ignored.
- `req` changes of non-owners take effect only at ARB/IDLE picks and at the dwell-end check.

## Timing
- Request to grant from IDLE: 1 edge. `req` is sampled at edge k; `grant`/`value` are valid after edge k.
- Owner source to `value`: 1 cycle of registered latency.
- Handover between different owners always includes exactly one cycle with `grant`=0.
- Full slot length is DWELL cycles of `grant` high, then 1 ARB cycle.
- The same source re-granted after ARB (sole requester left) restarts `cnt` at 0.
- Reset low at any edge forces all reset values at that edge, regardless of state. Any in-flight slot is abandoned.
- `owner` is stable for the whole HOLD period. `grant`, `owner` and `busy` change on the same edge.

## Configuration
- `DISPLAY_ARB_PRIORITY_EN` defined:
  - Source 0 preempts. In HOLD with `owner`!=0 and `req[0]`=1, the block goes to ARB at the next edge, regardless of `cnt`.
  - ARB then picks 0 unconditionally, ignoring rotation.
  - Source 0 itself still yields after DWELL if others request.
- Not defined: source 0 is an ordinary round-robin participant, with no preemption logic present.

## Test plan
- Reset held low 5 cycles with `req`=4'b1111: `grant`=0, `value`=0, `busy`=0 throughout. One edge after release: `grant`=4'b0001, `owner`=0.
- `req`=4'b0010, source 1 = 16'h1234, DWELL=4: `grant`=4'b0010 one edge later and stays high over 20 cycles with no gap. `value`=16'h1234. Changing source 1 to 16'hBEEF shows on `value` 1 cycle later.
- `req`=4'b0101, DWELL=4: repeating pattern of `grant`=0001 for 4 cycles, 0000 for 1 cycle, 0100 for 4 cycles, 0000 for 1 cycle.
- Owner 2 drops `req` at cnt=1 while `req[3]`=1: `grant` clears at the next edge, then `grant`=4'b1000 one edge later. Dropping all requests instead gives IDLE with `value`=IDLE_VALUE after the ARB cycle.
- Owner 2 mid-slot, DWELL=100, `req[0]` rises at cnt=10:
  - With `DISPLAY_ARB_PRIORITY_EN`: `grant`=0 at the next edge and 0001 one edge after.
  - Without it: `grant`=0100 until cnt=99, then ARB, then 0001 (rotation 3 first if requesting).
- Reset asserted during HOLD at cnt=50: the next edge gives `grant`=0, `value`=IDLE_VALUE, `busy`=0. After release, the grant restarts from index 0.
